rv32i_fetch_unit: RTL and testbench
===================================

Name: rv32i_fetch_unit

Overview:
- Parametrised instruction-fetch front end for the rv32i core.
- Replaces the single-cycle PC/next_pc path and the fixed-latency ROM read.
- Issues in-order fetches to a memory port with variable latency and keeps up to DEPTH requests/instructions in a prefetch FIFO.
- Delivers {pc, instr} to decode over a valid/ready handshake; supports branch/trap redirect with flush and discard of stale responses.

Parameters:
- XLEN, 32, address/PC width.
- RESET_VEC, 32'h8000_0000, PC after reset, truncated to XLEN.
- DEPTH, 4, prefetch FIFO entries and maximum outstanding requests; power of two, ≥2.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset
- stall  in  1  blocks issue of new memory requests
- redirect_valid  in  1  branch/jump/trap taken this cycle
- redirect_pc  in  XLEN  new fetch address
- mem_req_valid  out  1  fetch request
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  XLEN  fetch address
- mem_rsp_valid  in  1  read data returned; in order, no backpressure
- mem_rsp_data  in  32  instruction word
- instr_valid  out  1  FIFO head valid
- instr_ready  in  1  decode consumes head
- instr_data  out  32  instruction
- instr_pc  out  XLEN  PC of instruction
- misaligned  out  1  see Optional Feature; tied 0 when disabled

Behaviour:
- Clock and reset: clk is the clock. reset_n is asynchronous, active-low.
- Reset values:
  - fetch_pc=RESET_VEC; FIFO count=0; inflight=0; discard=0.
  - Outputs: mem_req_valid=0, instr_valid=0, instr_data=0, instr_pc=0, misaligned=0.
- Credit:
  - occupancy = count + inflight; inflight includes responses already marked for discard.
  - mem_req_valid = !stall && !redirect_valid && occupancy<DEPTH && !misaligned.
  - Combinational from registered state plus stall/redirect_valid.
  - Requests are per-cycle: memory must not require req_valid to persist until accepted.
- Issue:
  - mem_req_addr = fetch_pc.
  - On req_valid&&req_ready: inflight+1, fetch_pc += 4, wrapping modulo 2^XLEN.
- Response:
  - Each mem_rsp_valid decrements inflight.
  - If discard>0: discard-1 and data dropped.
  - Else: {pc,data} pushed at the tail; pc is taken from a tail-PC register advanced by 4 per push.
  - A push never overflows, because credit guarantees room.
  - Latency: rsp at cycle R → instr_valid at R+1.
- Output:
  - instr_valid = count!=0; head registered.
  - Pop on instr_valid&&instr_ready.
  - Push and pop in the same cycle leave count unchanged.
- Redirect at cycle T:
  - FIFO flushed (count=0); a pop in cycle T is void.
  - discard = inflight − (mem_rsp_valid?1:0). A response arriving in cycle T is counted in that subtraction and dropped.
  - No request issued in T.
  - fetch_pc = tail-PC = redirect_pc; first new request at T+1.
- Simultaneous redirect and stall: redirect still applied; issue resumes when stall drops.
- Inflight, discard and count are each limited to DEPTH; counter widths are $clog2(DEPTH+1).
- Reset mid-operation clears all state immediately. The memory shares reset_n, so no stale responses arrive after reset.

Optional Feature:
- Macro: RV32I_FETCH_MISALIGN_TRAP_EN.
- Enabled:
  - A redirect with redirect_pc[1:0]!=0 sets misaligned=1 at T+1.
  - Flush and discard proceed normally; issue is halted.
  - misaligned is held until the next aligned redirect, which clears it and resumes fetching.
- Disabled:
  - redirect_pc[1:0] are forced to 0.
  - misaligned is tied 0 and fetching continues.

Test Plan:
- Reset with RESET_VEC=32'h8000_0000, mem_req_ready=1, fixed 1-cycle memory, instr_ready=1 → addresses 8000_0000, 8000_0004, 8000_0008…; instr_pc matches each instr_data; one instruction per cycle in steady state.
- instr_ready=0 with DEPTH=4 → exactly 4 requests issued, then mem_req_valid=0; after one pop, exactly one further request.
- 3 requests in flight, redirect_valid with redirect_pc=32'h8000_0100 → the 3 late responses are dropped; first instr_valid shows instr_pc=8000_0100; no stale instruction is ever visible.
- Redirect in the same cycle as a mem_rsp_valid and a pop → both dropped; discard = inflight−1; the next delivered PC is the redirect target.
- fetch_pc=32'hFFFF_FFFC (XLEN=32), 2 fetches → addresses FFFF_FFFC then 0000_0000.
- With the macro, redirect to 8000_0102 → misaligned=1, no requests; redirect to 8000_0200 → misaligned=0, fetch resumes at 8000_0200. Without the macro, the same stimulus fetches 8000_0100.

Source files
------------

// File: rtl/rv32i_fetch_unit_if.sv
// Fetch-unit bus bundle: control inputs, memory request/response port and decode handshake.
// master = fetch unit side, slave = memory/decode/control side.
interface rv32i_fetch_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [XLEN-1:0] mem_req_addr;
  logic            mem_rsp_valid;
  logic [31:0]     mem_rsp_data;
  logic            instr_valid;
  logic            instr_ready;
  logic [31:0]     instr_data;
  logic [XLEN-1:0] instr_pc;
  logic            misaligned;

  modport master (
    input  stall, redirect_valid, redirect_pc, mem_req_ready, mem_rsp_valid, mem_rsp_data,
           instr_ready,
    output mem_req_valid, mem_req_addr, instr_valid, instr_data, instr_pc, misaligned
  );

  modport slave (
    output stall, redirect_valid, redirect_pc, mem_req_ready, mem_rsp_valid, mem_rsp_data,
           instr_ready,
    input  mem_req_valid, mem_req_addr, instr_valid, instr_data, instr_pc, misaligned
  );
endinterface

// File: rtl/rv32i_fetch_unit.sv
// rv32i instruction-fetch front end: credit-limited in-order fetch, prefetch FIFO, redirect flush.
// Optional misaligned-redirect trap enabled by defining RV32I_FETCH_MISALIGN_TRAP_EN.
module rv32i_fetch_unit #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(32'h8000_0000),
  parameter int unsigned     DEPTH     = 4
) (
  input logic               clk,
  input logic               reset_n,
  rv32i_fetch_unit_if.master bus_io
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [CntW:0] DepthOcc = (CntW + 1)'(DEPTH);

  typedef logic [CntW-1:0] cnt_t;
  typedef logic [PtrW-1:0] ptr_t;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] tail_pc_q, tail_pc_d;
  cnt_t            count_q, count_d;
  cnt_t            inflight_q, inflight_d;
  cnt_t            discard_q, discard_d;
  ptr_t            head_q, head_d;
  ptr_t            tail_q, tail_d;
  logic            misaligned_q, misaligned_d;
  logic [31:0]     data_q [DEPTH];
  logic [XLEN-1:0] pc_q   [DEPTH];

  logic [CntW:0]   occupancy;
  logic            req_valid, req_fire, push, pop, head_valid;
  logic [XLEN-1:0] redirect_tgt;

`ifdef RV32I_FETCH_MISALIGN_TRAP_EN
  assign redirect_tgt = bus_io.redirect_pc;
  assign misaligned_d = bus_io.redirect_valid ? (bus_io.redirect_pc[1:0] != 2'b00)
                                              : misaligned_q;
`else
  assign redirect_tgt = {bus_io.redirect_pc[XLEN-1:2], 2'b00};
  assign misaligned_d = 1'b0;
`endif

  // Outstanding responses (including ones to be discarded) reserve FIFO slots.
  assign occupancy  = {1'b0, count_q} + {1'b0, inflight_q};
  assign req_valid  = reset_n & ~bus_io.stall & ~bus_io.redirect_valid &
                      (occupancy < DepthOcc) & ~misaligned_q;
  assign req_fire   = req_valid & bus_io.mem_req_ready;
  assign head_valid = (count_q != '0);
  assign pop        = head_valid & bus_io.instr_ready & ~bus_io.redirect_valid;
  assign push       = bus_io.mem_rsp_valid & (discard_q == '0) & ~bus_io.redirect_valid;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    tail_pc_d  = tail_pc_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    discard_d  = discard_q;
    head_d     = head_q;
    tail_d     = tail_q;

    if (req_fire) begin
      inflight_d = inflight_d + cnt_t'(1);
      fetch_pc_d = fetch_pc_q + XLEN'(4);
    end
    if (bus_io.mem_rsp_valid) begin
      inflight_d = inflight_d - cnt_t'(1);
      if (discard_q != '0) discard_d = discard_q - cnt_t'(1);
    end
    if (push) begin
      tail_d    = tail_q + ptr_t'(1);
      tail_pc_d = tail_pc_q + XLEN'(4);
    end
    if (pop) head_d = head_q + ptr_t'(1);

    if (push && !pop)      count_d = count_q + cnt_t'(1);
    else if (pop && !push) count_d = count_q - cnt_t'(1);

    // A response landing in the redirect cycle is already dropped, so it is not discarded again.
    if (bus_io.redirect_valid) begin
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      discard_d  = inflight_q - cnt_t'(bus_io.mem_rsp_valid);
      inflight_d = inflight_q - cnt_t'(bus_io.mem_rsp_valid);
      fetch_pc_d = redirect_tgt;
      tail_pc_d  = redirect_tgt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_q   <= RESET_VEC;
      tail_pc_q    <= RESET_VEC;
      count_q      <= '0;
      inflight_q   <= '0;
      discard_q    <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      misaligned_q <= 1'b0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      tail_pc_q    <= tail_pc_d;
      count_q      <= count_d;
      inflight_q   <= inflight_d;
      discard_q    <= discard_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      misaligned_q <= misaligned_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else if (push) begin
      data_q[tail_q] <= bus_io.mem_rsp_data;
      pc_q[tail_q]   <= tail_pc_q;
    end
  end

  assign bus_io.mem_req_valid = req_valid;
  assign bus_io.mem_req_addr  = fetch_pc_q;
  assign bus_io.instr_valid   = head_valid;
  assign bus_io.instr_data    = head_valid ? data_q[head_q] : '0;
  assign bus_io.instr_pc      = head_valid ? pc_q[head_q] : '0;
  assign bus_io.misaligned    = misaligned_q;

endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// Directed bench for rv32i_fetch_unit with a 1-cycle in-order memory model that can hold responses.
// Define RV32I_FETCH_MISALIGN_TRAP_EN on both RTL and bench to exercise the misaligned trap.
module tb_rv32i_fetch_unit;

  localparam logic [31:0] Key = 32'h1357_9BDF;

  logic clk;
  logic reset_n;
  logic mem_hold;
  int   n_cmp;
  int   n_fail;
  int   fire_cnt;
  logic [31:0] mq[$];
  logic [31:0] req_log[$];

  rv32i_fetch_unit_if #(.XLEN(32)) bus ();

  rv32i_fetch_unit #(
    .XLEN     (32),
    .RESET_VEC(32'h8000_0000),
    .DEPTH    (4)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  // Memory: a request accepted at edge N returns data during the following cycle.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      bus.mem_rsp_valid <= 1'b0;
      bus.mem_rsp_data  <= '0;
    end else begin
      if (bus.mem_req_valid && bus.mem_req_ready) begin
        mq.push_back(bus.mem_req_addr);
        req_log.push_back(bus.mem_req_addr);
        fire_cnt++;
      end
      if (!mem_hold && mq.size() > 0) begin
        bus.mem_rsp_valid <= 1'b1;
        bus.mem_rsp_data  <= mq.pop_front() ^ Key;
      end else begin
        bus.mem_rsp_valid <= 1'b0;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset_n            = 1'b0;
    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.instr_ready    = 1'b1;
    mem_hold           = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0;
    bus.stall = 1'b0;
    bus.instr_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.mem_req_valid !== 1'b0) begin n_fail++;
      $display("FAIL reset_req_valid: got %b want 0", bus.mem_req_valid); end
    n_cmp++; if (bus.instr_valid !== 1'b0) begin n_fail++;
      $display("FAIL reset_instr_valid: got %b want 0", bus.instr_valid); end
    n_cmp++; if (bus.instr_data !== 32'h0) begin n_fail++;
      $display("FAIL reset_instr_data: got %h want 0", bus.instr_data); end
    n_cmp++; if (bus.instr_pc !== 32'h0) begin n_fail++;
      $display("FAIL reset_instr_pc: got %h want 0", bus.instr_pc); end
    n_cmp++; if (bus.misaligned !== 1'b0) begin n_fail++;
      $display("FAIL reset_misaligned: got %b want 0", bus.misaligned); end
    n_cmp++; if (bus.mem_req_addr !== 32'h8000_0000) begin n_fail++;
      $display("FAIL reset_req_addr: got %h want 80000000", bus.mem_req_addr); end
  endtask

  task automatic test_stream();
    int k;
    int base;
    logic [31:0] exp;
    base = req_log.size();
    reset_n = 1'b1;
    k = 0;
    while (bus.instr_valid !== 1'b1 && k < 10) begin @(negedge clk); k++; end
    n_cmp++; if (bus.instr_valid !== 1'b1) begin n_fail++;
      $display("FAIL stream_start: got instr_valid %b want 1 within 10 cycles", bus.instr_valid); end
    for (int i = 0; i < 6; i++) begin
      exp = 32'h8000_0000 + 32'(4 * i);
      n_cmp++;
      if (bus.instr_valid !== 1'b1 || bus.instr_pc !== exp || bus.instr_data !== (exp ^ Key)) begin
        n_fail++;
        $display("FAIL stream_instr%0d: got v=%b pc=%h d=%h want v=1 pc=%h d=%h", i,
                 bus.instr_valid, bus.instr_pc, bus.instr_data, exp, exp ^ Key);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (req_log.size() < base + 4) begin n_fail++;
      $display("FAIL stream_req_count: got %0d want >= 4", req_log.size() - base);
    end else begin
      for (int i = 0; i < 4; i++) begin
        exp = 32'h8000_0000 + 32'(4 * i);
        if (req_log[base+i] !== exp) begin n_fail++;
          $display("FAIL stream_req_addr%0d: got %h want %h", i, req_log[base+i], exp); end
      end
    end
  endtask

  task automatic test_backpressure();
    int f0;
    do_reset();
    bus.instr_ready = 1'b0;
    f0 = fire_cnt;
    repeat (12) @(negedge clk);
    n_cmp++; if (fire_cnt - f0 != 4) begin n_fail++;
      $display("FAIL bp_fill_reqs: got %0d want 4", fire_cnt - f0); end
    n_cmp++; if (bus.mem_req_valid !== 1'b0) begin n_fail++;
      $display("FAIL bp_full_req_valid: got %b want 0", bus.mem_req_valid); end
    n_cmp++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h8000_0000) begin n_fail++;
      $display("FAIL bp_head: got v=%b pc=%h want v=1 pc=80000000", bus.instr_valid,
               bus.instr_pc); end
    bus.instr_ready = 1'b1;
    @(negedge clk);
    bus.instr_ready = 1'b0;
    n_cmp++; if (bus.instr_pc !== 32'h8000_0004) begin n_fail++;
      $display("FAIL bp_after_pop_pc: got %h want 80000004", bus.instr_pc); end
    f0 = fire_cnt;
    repeat (8) @(negedge clk);
    n_cmp++; if (fire_cnt - f0 != 1) begin n_fail++;
      $display("FAIL bp_refill_reqs: got %0d want 1", fire_cnt - f0); end
    n_cmp++; if (bus.mem_req_valid !== 1'b0) begin n_fail++;
      $display("FAIL bp_refull_req_valid: got %b want 0", bus.mem_req_valid); end
  endtask

  task automatic test_redirect_discard();
    int f0;
    int got;
    int k;
    logic [31:0] exp;
    do_reset();
    mem_hold = 1'b1;
    f0 = fire_cnt;
    repeat (3) @(negedge clk);
    bus.stall = 1'b1;
    @(negedge clk);
    n_cmp++; if (fire_cnt - f0 != 3) begin n_fail++;
      $display("FAIL rd_inflight: got %0d want 3", fire_cnt - f0); end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0100;
    bus.stall          = 1'b0;
    #1;
    n_cmp++; if (bus.mem_req_valid !== 1'b0) begin n_fail++;
      $display("FAIL rd_no_issue: got %b want 0", bus.mem_req_valid); end
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    mem_hold = 1'b0;
    got = 0;
    k = 0;
    while (got < 4 && k < 30) begin
      if (bus.instr_valid === 1'b1) begin
        exp = 32'h8000_0100 + 32'(4 * got);
        n_cmp++;
        if (bus.instr_pc !== exp || bus.instr_data !== (exp ^ Key)) begin n_fail++;
          $display("FAIL rd_instr%0d: got pc=%h d=%h want pc=%h d=%h", got, bus.instr_pc,
                   bus.instr_data, exp, exp ^ Key);
        end
        got++;
      end
      @(negedge clk);
      k++;
    end
    n_cmp++; if (got != 4) begin n_fail++;
      $display("FAIL rd_delivered: got %0d want 4", got); end
  endtask

  task automatic test_redirect_collision();
    int got;
    int k;
    logic [31:0] exp;
    do_reset();
    repeat (6) @(negedge clk);
    n_cmp++; if (bus.mem_rsp_valid !== 1'b1 || bus.instr_valid !== 1'b1) begin n_fail++;
      $display("FAIL col_setup: got rsp=%b iv=%b want 1 1", bus.mem_rsp_valid, bus.instr_valid);
    end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0040;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    n_cmp++; if (bus.instr_valid !== 1'b0) begin n_fail++;
      $display("FAIL col_flushed: got instr_valid %b want 0", bus.instr_valid); end
    got = 0;
    k = 0;
    while (got < 2 && k < 20) begin
      if (bus.instr_valid === 1'b1) begin
        exp = 32'h8000_0040 + 32'(4 * got);
        n_cmp++;
        if (bus.instr_pc !== exp || bus.instr_data !== (exp ^ Key)) begin n_fail++;
          $display("FAIL col_instr%0d: got pc=%h d=%h want pc=%h d=%h", got, bus.instr_pc,
                   bus.instr_data, exp, exp ^ Key);
        end
        got++;
      end
      @(negedge clk);
      k++;
    end
    n_cmp++; if (got != 2) begin n_fail++;
      $display("FAIL col_delivered: got %0d want 2", got); end
  endtask

  task automatic test_wrap();
    int base;
    int got;
    int k;
    logic [31:0] exp;
    do_reset();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    base = req_log.size();
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    got = 0;
    k = 0;
    while (got < 2 && k < 20) begin
      if (bus.instr_valid === 1'b1) begin
        exp = 32'hFFFF_FFFC + 32'(4 * got);
        n_cmp++;
        if (bus.instr_pc !== exp || bus.instr_data !== (exp ^ Key)) begin n_fail++;
          $display("FAIL wrap_instr%0d: got pc=%h d=%h want pc=%h d=%h", got, bus.instr_pc,
                   bus.instr_data, exp, exp ^ Key);
        end
        got++;
      end
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (req_log.size() < base + 2) begin n_fail++;
      $display("FAIL wrap_reqs: got %0d want >= 2", req_log.size() - base);
    end else if (req_log[base] !== 32'hFFFF_FFFC || req_log[base+1] !== 32'h0000_0000) begin
      n_fail++;
      $display("FAIL wrap_addr: got %h %h want fffffffc 00000000", req_log[base],
               req_log[base+1]);
    end
  endtask

  task automatic test_misalign();
    int base;
    do_reset();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0102;
    base = req_log.size();
    @(negedge clk);
    bus.redirect_valid = 1'b0;
`ifdef RV32I_FETCH_MISALIGN_TRAP_EN
    n_cmp++; if (bus.misaligned !== 1'b1) begin n_fail++;
      $display("FAIL mis_set: got %b want 1", bus.misaligned); end
    repeat (5) @(negedge clk);
    n_cmp++; if (req_log.size() != base || bus.mem_req_valid !== 1'b0) begin n_fail++;
      $display("FAIL mis_halt: got %0d reqs valid=%b want 0 reqs valid=0",
               req_log.size() - base, bus.mem_req_valid); end
    n_cmp++; if (bus.misaligned !== 1'b1) begin n_fail++;
      $display("FAIL mis_hold: got %b want 1", bus.misaligned); end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0200;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    n_cmp++; if (bus.misaligned !== 1'b0) begin n_fail++;
      $display("FAIL mis_clear: got %b want 0", bus.misaligned); end
    repeat (4) @(negedge clk);
    n_cmp++;
    if (req_log.size() <= base) begin n_fail++;
      $display("FAIL mis_resume: got 0 reqs want >= 1");
    end else if (req_log[base] !== 32'h8000_0200) begin n_fail++;
      $display("FAIL mis_resume_addr: got %h want 80000200", req_log[base]);
    end
`else
    n_cmp++; if (bus.misaligned !== 1'b0) begin n_fail++;
      $display("FAIL mis_tied: got %b want 0", bus.misaligned); end
    repeat (4) @(negedge clk);
    n_cmp++;
    if (req_log.size() <= base) begin n_fail++;
      $display("FAIL mis_fetch: got 0 reqs want >= 1");
    end else if (req_log[base] !== 32'h8000_0100) begin n_fail++;
      $display("FAIL mis_fetch_addr: got %h want 80000100", req_log[base]);
    end
`endif
  endtask

  initial begin
    clk                = 1'b0;
    reset_n            = 1'b0;
    mem_hold           = 1'b0;
    n_cmp              = 0;
    n_fail             = 0;
    fire_cnt           = 0;
    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.mem_req_ready  = 1'b1;
    bus.instr_ready    = 1'b1;

    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_discard();
    test_redirect_collision();
    test_wrap();
    test_misalign();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
